// File: rtl/fft_bitrev_input_buffer.sv
// Single-buffered frame store feeding a radix-2 DIT butterfly: fills N samples in
// natural order, then drains them as N/2 (x1, x2) pairs in bit-reversed order.
module fft_bitrev_input_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int N          = 8,
  parameter int LOG2N      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_r,
  input  logic [DATA_WIDTH-1:0] in_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] x1_r,
  output logic [DATA_WIDTH-1:0] x1_i,
  output logic [DATA_WIDTH-1:0] x2_r,
  output logic [DATA_WIDTH-1:0] x2_i
);

  localparam int PW = (LOG2N > 1) ? LOG2N - 1 : 1;
  localparam int EW = 2 * DATA_WIDTH;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic [PW-1:0]    p_q, p_d;
  logic [EW-1:0]    mem_q [N];

  logic             in_fire_s;
  logic             out_fire_s;
  logic             p_last_s;
  logic [LOG2N-1:0] even_idx_s;
  logic [LOG2N-1:0] odd_idx_s;
  logic [LOG2N-1:0] rd_idx1_s;
  logic [LOG2N-1:0] rd_idx2_s;
  logic [EW-1:0]    rd_word1_s;
  logic [EW-1:0]    rd_word2_s;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int k = 0; k < LOG2N; k++) begin
      r[k] = v[LOG2N-1-k];
    end
    return r;
  endfunction

  // Handshake decode; reset forces both sides of the stream idle immediately.
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    if (rst) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
    end else begin
      in_ready  = (state_q == FILL);
      out_valid = (state_q == DRAIN);
    end
    in_fire_s  = in_valid && in_ready;
    out_fire_s = out_valid && out_ready;
  end

  // Pair addressing: 2p and 2p+1 truncated to LOG2N bits (N=2 has a single pair).
  always_comb begin
    even_idx_s = LOG2N'({p_q, 1'b0});
    odd_idx_s  = LOG2N'({p_q, 1'b1});
    rd_idx1_s  = bitrev(even_idx_s);
    rd_idx2_s  = bitrev(odd_idx_s);
    rd_word1_s = mem_q[rd_idx1_s];
    rd_word2_s = mem_q[rd_idx2_s];
    p_last_s   = (p_q == PW'(N/2 - 1));
  end

  // Output data path, zeroed whenever no pair is being offered.
  always_comb begin
    x1_r     = {DATA_WIDTH{1'b0}};
    x1_i     = {DATA_WIDTH{1'b0}};
    x2_r     = {DATA_WIDTH{1'b0}};
    x2_i     = {DATA_WIDTH{1'b0}};
    out_last = 1'b0;
    if (out_valid) begin
      x1_r     = rd_word1_s[EW-1:DATA_WIDTH];
      x1_i     = rd_word1_s[DATA_WIDTH-1:0];
      x2_r     = rd_word2_s[EW-1:DATA_WIDTH];
      x2_i     = rd_word2_s[DATA_WIDTH-1:0];
      out_last = p_last_s;
    end else begin
      out_last = 1'b0;
    end
  end

  // Next-state: counters only wrap on the transition that leaves their state.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    p_d      = p_q;
    case (state_q)
      FILL: begin
        if (in_fire_s) begin
          if (wr_cnt_q == LOG2N'(N - 1)) begin
            wr_cnt_d = {LOG2N{1'b0}};
            state_d  = DRAIN;
          end else begin
            wr_cnt_d = wr_cnt_q + LOG2N'(1);
          end
        end else begin
          wr_cnt_d = wr_cnt_q;
        end
      end
      DRAIN: begin
        if (out_fire_s) begin
          if (p_last_s) begin
            p_d     = {PW{1'b0}};
            state_d = FILL;
          end else begin
            p_d = p_q + PW'(1);
          end
        end else begin
          p_d = p_q;
        end
      end
      default: begin
        state_d  = FILL;
        wr_cnt_d = {LOG2N{1'b0}};
        p_d      = {PW{1'b0}};
      end
    endcase
  end

  // Control state and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      wr_cnt_q <= {LOG2N{1'b0}};
      p_q      <= {PW{1'b0}};
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      p_q      <= p_d;
    end
  end

  // Frame storage; contents survive reset and are simply overwritten by the next frame.
  always_ff @(posedge clk) begin
    if (in_fire_s) begin
      mem_q[wr_cnt_q] <= {in_r, in_i};
    end
  end

endmodule

// File: tb/tb_fft_bitrev_input_buffer.sv
// Randomized and directed bench for fft_bitrev_input_buffer (N=8 and N=2 instances)
// against a frame-level reference model.
module tb_fft_bitrev_input_buffer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_last;
  logic [63:0] in_r = 64'd0, in_i = 64'd0, x1_r, x1_i, x2_r, x2_i;

  logic        rst2 = 1'b1;
  logic        in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b0, out_last2;
  logic [63:0] in_r2 = 64'd0, in_i2 = 64'd0, x1_r2, x1_i2, x2_r2, x2_i2;

  fft_bitrev_input_buffer #(.DATA_WIDTH(64), .N(8), .LOG2N(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_i(in_i), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .x1_r(x1_r), .x1_i(x1_i), .x2_r(x2_r), .x2_i(x2_i));

  fft_bitrev_input_buffer #(.DATA_WIDTH(64), .N(2), .LOG2N(1)) dut2 (
    .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_r(in_r2), .in_i(in_i2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_last(out_last2), .x1_r(x1_r2), .x1_i(x1_i2), .x2_r(x2_r2), .x2_i(x2_i2));

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference model: the stored frame plus where we are in the fill/drain cycle.
  logic [63:0] m_re [8];
  logic [63:0] m_im [8];
  bit          m_drain = 1'b0;
  int          m_wr = 0;
  int          m_p  = 0;

  typedef struct {
    logic [63:0] x1r, x1i, x2r, x2i;
    logic        last;
  } pair_t;
  pair_t obs[$];

  function automatic int rev3(input int k);
    return ((k % 2) * 4) + (((k / 2) % 2) * 2) + ((k / 4) % 2);
  endfunction

  task automatic step(input bit r, input bit v, input logic [63:0] dr, input logic [63:0] di,
                      input bit ordy);
    bit          e_rdy, e_vld, e_last;
    int          i1;
    logic [63:0] e1r, e1i, e2r, e2i;
    pair_t       pr;
    rst = r; in_valid = v; in_r = dr; in_i = di; out_ready = ordy;
    #1;
    e_rdy  = !r && !m_drain;
    e_vld  = !r && m_drain;
    i1     = rev3(2 * m_p);
    e_last = e_vld && (m_p == 3);
    e1r = e_vld ? m_re[i1] : 64'd0;
    e1i = e_vld ? m_im[i1] : 64'd0;
    e2r = e_vld ? m_re[i1 + 4] : 64'd0;
    e2i = e_vld ? m_im[i1 + 4] : 64'd0;
    chk_cnt++; if (in_ready !== e_rdy) $display("FAIL in_ready t=%0t got %b exp %b", $time, in_ready, e_rdy); else pass_cnt++;
    chk_cnt++; if (out_valid !== e_vld) $display("FAIL out_valid t=%0t got %b exp %b", $time, out_valid, e_vld); else pass_cnt++;
    chk_cnt++; if (out_last !== e_last) $display("FAIL out_last t=%0t got %b exp %b", $time, out_last, e_last); else pass_cnt++;
    chk_cnt++; if (x1_r !== e1r) $display("FAIL x1_r t=%0t got %h exp %h", $time, x1_r, e1r); else pass_cnt++;
    chk_cnt++; if (x1_i !== e1i) $display("FAIL x1_i t=%0t got %h exp %h", $time, x1_i, e1i); else pass_cnt++;
    chk_cnt++; if (x2_r !== e2r) $display("FAIL x2_r t=%0t got %h exp %h", $time, x2_r, e2r); else pass_cnt++;
    chk_cnt++; if (x2_i !== e2i) $display("FAIL x2_i t=%0t got %h exp %h", $time, x2_i, e2i); else pass_cnt++;
    if (out_valid === 1'b1 && ordy) begin
      pr.x1r = x1_r; pr.x1i = x1_i; pr.x2r = x2_r; pr.x2i = x2_i; pr.last = out_last;
      obs.push_back(pr);
    end
    if (r) begin
      m_drain = 1'b0; m_wr = 0; m_p = 0;
    end else if (!m_drain) begin
      if (v) begin
        m_re[m_wr] = dr; m_im[m_wr] = di; m_wr++;
        if (m_wr == 8) begin m_wr = 0; m_drain = 1'b1; end
      end
    end else if (ordy) begin
      m_p++;
      if (m_p == 4) begin m_p = 0; m_drain = 1'b0; end
    end
    @(posedge clk); #1;
  endtask

  task automatic feed(input int cnt, input logic [63:0] rb, input logic [63:0] ib,
                      input bit tog, input bit rnd);
    int k, cyc;
    bit v, acc;
    logic [63:0] dr, di;
    k = 0; cyc = 0;
    while (k < cnt && cyc < 100) begin
      v   = tog ? (cyc % 2 == 0) : (rnd ? bit'($urandom_range(0, 1)) : 1'b1);
      acc = v && !m_drain;
      dr  = rnd ? {$urandom, $urandom} : rb + 64'(k);
      di  = rnd ? {$urandom, $urandom} : ib + 64'(k);
      step(1'b0, v, dr, di, 1'b1);
      if (acc) k++;
      cyc++;
    end
    chk_cnt++; if (k < cnt) $display("FAIL feed_timeout got %0d exp %0d", k, cnt); else pass_cnt++;
  endtask

  task automatic drain(input bit rnd);
    int cyc;
    cyc = 0;
    while (m_drain && cyc < 100) begin
      step(1'b0, 1'b0, 64'd0, 64'd0, rnd ? bit'($urandom_range(0, 1)) : 1'b1);
      cyc++;
    end
    chk_cnt++; if (m_drain) $display("FAIL drain_timeout got %0d exp 0", cyc); else pass_cnt++;
  endtask

  task automatic test_reset;
    step(1'b1, 1'b1, 64'd5, 64'd6, 1'b1);
    step(1'b1, 1'b0, 64'd0, 64'd0, 1'b1);
  endtask

  task automatic test_natural_order;
    logic [63:0] e1 [4];
    logic [63:0] e2 [4];
    e1 = '{64'd0, 64'd2, 64'd1, 64'd3};
    e2 = '{64'd4, 64'd6, 64'd5, 64'd7};
    obs.delete();
    feed(8, 64'd0, 64'd0, 1'b0, 1'b0);
    drain(1'b0);
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if (i >= obs.size() || obs[i].x1r !== e1[i] || obs[i].x2r !== e2[i] || obs[i].last !== (i == 3))
        $display("FAIL order pair%0d got %0d,%0d exp %0d,%0d", i,
                 (i < obs.size()) ? obs[i].x1r : 64'hx, (i < obs.size()) ? obs[i].x2r : 64'hx, e1[i], e2[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_toggle_valid;
    logic [63:0] e1 [4];
    logic [63:0] e2 [4];
    e1 = '{64'd100, 64'd102, 64'd101, 64'd103};
    e2 = '{64'd104, 64'd106, 64'd105, 64'd107};
    obs.delete();
    feed(8, 64'd0, 64'd100, 1'b1, 1'b0);
    drain(1'b0);
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if (i >= obs.size() || obs[i].x1i !== e1[i] || obs[i].x2i !== e2[i])
        $display("FAIL toggle_imag pair%0d got %0d,%0d exp %0d,%0d", i,
                 (i < obs.size()) ? obs[i].x1i : 64'hx, (i < obs.size()) ? obs[i].x2i : 64'hx, e1[i], e2[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure;
    feed(8, 64'd0, 64'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 64'd0, 64'd0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      chk_cnt++;
      if (x1_r !== 64'd2 || x2_r !== 64'd6 || out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL hold cyc%0d got %0d,%0d v=%b r=%b exp 2,6 v=1 r=0", c, x1_r, x2_r, out_valid, in_ready);
      else pass_cnt++;
      step(1'b0, 1'b1, 64'd99, 64'd99, 1'b0);
    end
    drain(1'b0);
  endtask

  task automatic test_back_to_back;
    int k, cyc;
    bit v, acc;
    logic [63:0] e1 [4];
    logic [63:0] e2 [4];
    e1 = '{64'd10, 64'd12, 64'd11, 64'd13};
    e2 = '{64'd14, 64'd16, 64'd15, 64'd17};
    obs.delete();
    k = 0; cyc = 0;
    while ((k < 16 || m_drain) && cyc < 200) begin
      v   = (k < 16);
      acc = v && !m_drain;
      step(1'b0, v, (k < 8) ? 64'(k) : 64'(k + 2), 64'd0, 1'b1);
      if (acc) k++;
      cyc++;
    end
    chk_cnt++; if (obs.size() != 8) $display("FAIL b2b_count got %0d exp 8", obs.size()); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if (i + 4 >= obs.size() || obs[i+4].x1r !== e1[i] || obs[i+4].x2r !== e2[i])
        $display("FAIL b2b pair%0d got %0d,%0d exp %0d,%0d", i,
                 (i + 4 < obs.size()) ? obs[i+4].x1r : 64'hx, (i + 4 < obs.size()) ? obs[i+4].x2r : 64'hx, e1[i], e2[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid;
    feed(5, 64'd50, 64'd60, 1'b0, 1'b0);
    step(1'b1, 1'b1, 64'd1, 64'd1, 1'b1);
    step(1'b1, 1'b0, 64'd0, 64'd0, 1'b1);
    feed(8, 64'd0, 64'd0, 1'b0, 1'b1);
    drain(1'b0);
    feed(8, 64'd0, 64'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 64'd0, 64'd0, 1'b1);
    step(1'b0, 1'b0, 64'd0, 64'd0, 1'b1);
    step(1'b1, 1'b0, 64'd0, 64'd0, 1'b1);
    step(1'b1, 1'b0, 64'd0, 64'd0, 1'b1);
    feed(8, 64'd0, 64'd0, 1'b0, 1'b1);
    drain(1'b0);
  endtask

  task automatic test_random;
    for (int f = 0; f < 4; f++) begin
      feed(8, 64'd0, 64'd0, 1'b0, 1'b1);
      drain(1'b1);
    end
  endtask

  task automatic test_n2;
    rst2 = 1'b1; out_ready2 = 1'b0; in_valid2 = 1'b0;
    @(posedge clk); #1;
    chk_cnt++; if (in_ready2 !== 1'b0 || out_valid2 !== 1'b0) $display("FAIL n2_reset got r=%b v=%b exp 0 0", in_ready2, out_valid2); else pass_cnt++;
    rst2 = 1'b0; #1;
    chk_cnt++; if (in_ready2 !== 1'b1) $display("FAIL n2_ready got %b exp 1", in_ready2); else pass_cnt++;
    in_valid2 = 1'b1; in_r2 = 64'd7; in_i2 = 64'hFFFF_FFFF_FFFF_FFFD;
    @(posedge clk); #1;
    in_r2 = 64'd5; in_i2 = 64'd2;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    for (int c = 0; c < 2; c++) begin
      chk_cnt++;
      if (out_valid2 !== 1'b1 || out_last2 !== 1'b1 || in_ready2 !== 1'b0 || x1_r2 !== 64'd7 ||
          x1_i2 !== 64'hFFFF_FFFF_FFFF_FFFD || x2_r2 !== 64'd5 || x2_i2 !== 64'd2)
        $display("FAIL n2_pair got v=%b l=%b x1=(%0d,%h) x2=(%0d,%0d) exp v=1 l=1 x1=(7,fffffffffffffffd) x2=(5,2)",
                 out_valid2, out_last2, x1_r2, x1_i2, x2_r2, x2_i2);
      else pass_cnt++;
      out_ready2 = (c == 1);
      @(posedge clk); #1;
    end
    chk_cnt++;
    if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1 || x1_r2 !== 64'd0)
      $display("FAIL n2_return got v=%b r=%b x1_r=%0d exp 0 1 0", out_valid2, in_ready2, x1_r2);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin m_re[i] = 64'd0; m_im[i] = 64'd0; end
    @(posedge clk); #1;
    test_reset;
    test_natural_order;
    test_toggle_valid;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_random;
    test_n2;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
